// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter that lets the fetch unit (port 0) and the load/store unit (port 1)
// share one AXI-lite master port. It runs one read or write transaction at a time.
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,

    input  logic                  req0_valid,
    input  logic                  req0_wen,
    input  logic [ADDR_W-1:0]     req0_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    input  logic [DATA_W/8-1:0]   req0_wstrb,
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic [DATA_W-1:0]     resp0_rdata,
    output logic                  resp0_err,

    input  logic                  req1_valid,
    input  logic                  req1_wen,
    input  logic [ADDR_W-1:0]     req1_addr,
    input  logic [DATA_W-1:0]     req1_wdata,
    input  logic [DATA_W/8-1:0]   req1_wstrb,
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic [DATA_W-1:0]     resp1_rdata,
    output logic                  resp1_err,

    output logic [ADDR_W-1:0]     ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY,

    output logic [ADDR_W-1:0]     AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [2:0]            AWPROT,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t                state, state_nxt;
    logic                  last, last_nxt;
    logic                  owner, owner_nxt;
    logic [ADDR_W-1:0]     addr_q, addr_nxt;
    logic [DATA_W-1:0]     wdata_q, wdata_nxt;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_nxt;
    logic                  arvalid_nxt, rready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt;
    logic                  resp0_valid_nxt, resp1_valid_nxt;
    logic                  resp0_err_nxt, resp1_err_nxt;
    logic [DATA_W-1:0]     resp0_rdata_nxt, resp1_rdata_nxt;
    logic                  sel_wen;
    logic                  gnt0, gnt1;

    // `last` records the previous winner; on a tie the other port is granted.
    assign gnt0 = req0_valid & (~req1_valid | last);
    assign gnt1 = req1_valid & (~req0_valid | ~last);

    // ready is the only combinational output and is held low while reset is asserted.
    assign req0_ready = ARESETN & (state == IDLE) & gnt0;
    assign req1_ready = ARESETN & (state == IDLE) & gnt1;

    assign ARADDR = addr_q;
    assign AWADDR = addr_q;
    assign WDATA  = wdata_q;
    assign WSTRB  = wstrb_q;
    assign AWPROT = 3'b000;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            ARVALID     <= 1'b0;
            RREADY      <= 1'b0;
            AWVALID     <= 1'b0;
            WVALID      <= 1'b0;
            BREADY      <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_err   <= 1'b0;
            resp1_err   <= 1'b0;
            resp0_rdata <= '0;
            resp1_rdata <= '0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            owner       <= owner_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            wstrb_q     <= wstrb_nxt;
            ARVALID     <= arvalid_nxt;
            RREADY      <= rready_nxt;
            AWVALID     <= awvalid_nxt;
            WVALID      <= wvalid_nxt;
            BREADY      <= bready_nxt;
            resp0_valid <= resp0_valid_nxt;
            resp1_valid <= resp1_valid_nxt;
            resp0_err   <= resp0_err_nxt;
            resp1_err   <= resp1_err_nxt;
            resp0_rdata <= resp0_rdata_nxt;
            resp1_rdata <= resp1_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_nxt        = last;
        owner_nxt       = owner;
        addr_nxt        = addr_q;
        wdata_nxt       = wdata_q;
        wstrb_nxt       = wstrb_q;
        arvalid_nxt     = ARVALID;
        rready_nxt      = RREADY;
        awvalid_nxt     = AWVALID;
        wvalid_nxt      = WVALID;
        bready_nxt      = BREADY;
        resp0_valid_nxt = 1'b0;
        resp1_valid_nxt = 1'b0;
        resp0_err_nxt   = 1'b0;
        resp1_err_nxt   = 1'b0;
        resp0_rdata_nxt = resp0_rdata;
        resp1_rdata_nxt = resp1_rdata;
        sel_wen         = gnt1 ? req1_wen : req0_wen;

        case (state)
            IDLE: begin
                if (gnt0 | gnt1) begin
                    owner_nxt = gnt1;
                    last_nxt  = gnt1;
                    addr_nxt  = gnt1 ? req1_addr  : req0_addr;
                    wdata_nxt = gnt1 ? req1_wdata : req0_wdata;
                    wstrb_nxt = gnt1 ? req1_wstrb : req0_wstrb;
                    if (sel_wen) begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = WR_REQ;
                    end else begin
                        arvalid_nxt = 1'b1;
                        state_nxt   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (ARREADY) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    rready_nxt = 1'b0;
                    if (owner) begin
                        resp1_valid_nxt = 1'b1;
                        resp1_err_nxt   = (RRESP != 2'b00);
                        resp1_rdata_nxt = RDATA;
                    end else begin
                        resp0_valid_nxt = 1'b1;
                        resp0_err_nxt   = (RRESP != 2'b00);
                        resp0_rdata_nxt = RDATA;
                    end
                    state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; a finished channel stays low.
                if (AWREADY) awvalid_nxt = 1'b0;
                if (WREADY)  wvalid_nxt  = 1'b0;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    bready_nxt = 1'b0;
                    if (owner) begin
                        resp1_valid_nxt = 1'b1;
                        resp1_err_nxt   = (BRESP != 2'b00);
                    end else begin
                        resp0_valid_nxt = 1'b1;
                        resp0_err_nxt   = (BRESP != 2'b00);
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed vector table, hand-built corner sequences,
// then a randomized run against a transaction-level reference model.
module tb_axi_lite_arbiter;

    localparam int NRAND = 40;
    localparam int LIMIT = 20000;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        req0_valid, req0_wen, req1_valid, req1_wen;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [3:0]  req0_wstrb, req1_wstrb;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic [31:0] ARADDR, AWADDR, WDATA, RDATA;
    logic        ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY;
    logic        BVALID, BREADY;
    logic [1:0]  RRESP, BRESP;
    logic [2:0]  AWPROT;
    logic [3:0]  WSTRB;

    int total = 0;
    int bad   = 0;

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req0_valid(req0_valid), .req0_wen(req0_wen), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_wen(req1_wen), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWPROT(AWPROT),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial forever #5 ACLK = ~ACLK;

    typedef struct {
        int          port;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    // reference-model state for the randomized run
    logic [31:0] ref_mem[8];
    logic [31:0] slave_mem[8];
    logic [31:0] held[2];
    logic        v[2], rw[2];
    logic [31:0] ra[2], rd[2];
    logic [3:0]  rs[2];
    int          issued[2], done[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_ready(input int p);
        return (p == 1) ? req1_ready : req0_ready;
    endfunction
    function automatic logic get_rv(input int p);
        return (p == 1) ? resp1_valid : resp0_valid;
    endfunction
    function automatic logic [31:0] get_rdata(input int p);
        return (p == 1) ? resp1_rdata : resp0_rdata;
    endfunction
    function automatic logic get_err(input int p);
        return (p == 1) ? resp1_err : resp0_err;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] base_addr(input int p, input int k);
        return 32'h4000_0000 + 32'(p) * 32'h100 + 32'(k) * 4;
    endfunction

    task automatic set_req(input int p, input logic vld, input logic wen, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (p == 1) begin
            req1_valid = vld; req1_wen = wen; req1_addr = a; req1_wdata = d; req1_wstrb = s;
        end else begin
            req0_valid = vld; req0_wen = wen; req0_addr = a; req0_wdata = d; req0_wstrb = s;
        end
    endtask

    task automatic clear_inputs();
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        clear_inputs();
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    // One transaction against a zero-wait slave: ready at T, VALID at T+1, resp at T+3.
    task automatic run_vec(input vec_t t);
        @(negedge ACLK);
        set_req(t.port, 1, t.wen, t.addr, t.wdata, t.wstrb);
        #1;
        chk("vec_ready", get_ready(t.port), 1);
        chk("vec_other_ready", get_ready(1 - t.port), 0);
        @(negedge ACLK);
        set_req(t.port, 0, 0, 0, 0, 0);
        if (!t.wen) begin
            chk("vec_arvalid", ARVALID, 1);
            chk("vec_araddr", ARADDR, t.addr);
            chk("vec_awvalid_idle", AWVALID, 0);
            ARREADY = 1;
        end else begin
            chk("vec_awvalid", AWVALID, 1);
            chk("vec_wvalid", WVALID, 1);
            chk("vec_awaddr", AWADDR, t.addr);
            chk("vec_wdata", WDATA, t.wdata);
            chk("vec_wstrb", WSTRB, t.wstrb);
            chk("vec_arvalid_idle", ARVALID, 0);
            AWREADY = 1; WREADY = 1;
        end
        @(negedge ACLK);
        ARREADY = 0; AWREADY = 0; WREADY = 0;
        if (!t.wen) begin
            chk("vec_rready", RREADY, 1);
            RVALID = 1; RDATA = t.s_rdata; RRESP = t.s_resp;
        end else begin
            chk("vec_bready", BREADY, 1);
            BVALID = 1; BRESP = t.s_resp;
        end
        @(negedge ACLK);
        RVALID = 0; BVALID = 0; RRESP = 0; BRESP = 0;
        chk("vec_resp_valid", get_rv(t.port), 1);
        chk("vec_resp_rdata", get_rdata(t.port), t.exp_rdata);
        chk("vec_resp_err", get_err(t.port), t.exp_err);
        chk("vec_other_resp", get_rv(1 - t.port), 0);
        @(negedge ACLK);
        chk("vec_resp_pulse_end", get_rv(t.port), 0);
        chk("vec_err_pulse_end", get_err(t.port), 0);
    endtask

    initial begin
        logic        busy_m, last_m, own_m, e_wen, pend_resp, pend_err;
        logic        r_pend, rv, bv, aw_seen, w_seen, wr_applied;
        logic        hold_ar, hold_aw, hold_w;
        logic [31:0] e_addr, e_wdata, e_rd, sl_awaddr, sl_wdata;
        logic [31:0] p_araddr, p_awaddr, p_wdata, acc_addr;
        logic [3:0]  e_wstrb, sl_wstrb, p_wstrb;
        logic [2:0]  sl_idx;
        int          pend_port, cyc, p;
        int          k[2];

        vecs[0] = '{0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011, 32'h0, 2'b00, 32'h0, 1'b0};
        vecs[2] = '{1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{0, 1'b1, 32'h0000_3000, 32'hAABB_CCDD, 4'b1111, 32'h0, 2'b11, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{1, 1'b1, 32'h0000_4000, 32'h5555_AAAA, 4'b1000, 32'h0, 2'b01, 32'hCAFE_F00D, 1'b1};
        vecs[5] = '{0, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'h0000_0001, 2'b00, 32'h0000_0001, 1'b0};

        do_reset();
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_bready", BREADY, 0);
        chk("rst_resp", {resp0_valid, resp1_valid, resp0_err, resp1_err}, 0);
        chk("rst_rdata0", resp0_rdata, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_awprot", AWPROT, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // split write: AW completes two cycles before W
        @(negedge ACLK);
        set_req(1, 1, 1, 32'h1000, 32'h1234_5678, 4'b0011);
        #1 chk("split_ready", req1_ready, 1);
        @(negedge ACLK);
        set_req(1, 0, 0, 0, 0, 0);
        chk("split_aw_t1", {AWVALID, WVALID}, 2'b11);
        AWREADY = 1;
        @(negedge ACLK);
        AWREADY = 0;
        chk("split_aw_dropped", {AWVALID, WVALID, BREADY}, 3'b010);
        @(negedge ACLK);
        chk("split_w_held", {AWVALID, WVALID, BREADY}, 3'b010);
        chk("split_wdata", WDATA, 32'h1234_5678);
        WREADY = 1;
        @(negedge ACLK);
        WREADY = 0;
        chk("split_bready", {AWVALID, WVALID, BREADY}, 3'b001);
        BVALID = 1;
        @(negedge ACLK);
        BVALID = 0;
        chk("split_resp", resp1_valid, 1);
        chk("split_rdata_kept", resp1_rdata, 32'hCAFE_F00D);
        @(negedge ACLK);
        chk("split_resp_once", resp1_valid, 0);

        // both ports continuously reading: grants alternate starting with port 0
        do_reset();
        @(negedge ACLK);
        k[0] = 0; k[1] = 0;
        set_req(0, 1, 0, base_addr(0, 0), 0, 0);
        set_req(1, 1, 0, base_addr(1, 0), 0, 0);
        for (int i = 0; i < 8; i++) begin
            p = i % 2;
            #1;
            chk("rr_ready_win", get_ready(p), 1);
            chk("rr_ready_lose", get_ready(1 - p), 0);
            acc_addr = base_addr(p, k[p]);
            @(negedge ACLK);
            k[p]++;
            if (k[p] < 4) set_req(p, 1, 0, base_addr(p, k[p]), 0, 0);
            else set_req(p, 0, 0, 0, 0, 0);
            #1;
            chk("rr_busy_ready", get_ready(1 - p), 0);
            chk("rr_araddr", ARADDR, acc_addr);
            chk("rr_arvalid", ARVALID, 1);
            ARREADY = 1;
            @(negedge ACLK);
            ARREADY = 0;
            chk("rr_rready", RREADY, 1);
            RVALID = 1; RDATA = acc_addr ^ 32'h5A5A_5A5A;
            @(negedge ACLK);
            RVALID = 0;
            chk("rr_resp", get_rv(p), 1);
            chk("rr_resp_other", get_rv(1 - p), 0);
            chk("rr_rdata", get_rdata(p), acc_addr ^ 32'h5A5A_5A5A);
        end
        #1 chk("rr_all_served", {req0_ready, req1_ready}, 2'b00);

        // reset while RD_DATA waits with RVALID pending
        @(negedge ACLK);
        set_req(0, 1, 0, 32'h7000, 0, 0);
        #1 chk("rst_mid_ready", req0_ready, 1);
        @(negedge ACLK);
        set_req(0, 0, 0, 0, 0, 0);
        ARREADY = 1;
        @(negedge ACLK);
        ARREADY = 0;
        chk("rst_mid_rready_pre", RREADY, 1);
        RVALID = 1; RDATA = 32'h1111_2222;
        ARESETN = 0;
        set_req(1, 1, 0, 32'h7100, 0, 0);
        #1;
        chk("rst_mid_ctrl", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 0);
        chk("rst_mid_resp", {resp0_valid, resp1_valid, resp0_err, resp1_err}, 0);
        chk("rst_mid_rdata0", resp0_rdata, 0);
        chk("rst_mid_rdata1", resp1_rdata, 0);
        chk("rst_mid_araddr", ARADDR, 0);
        chk("rst_mid_ready1", req1_ready, 0);
        @(negedge ACLK);
        RVALID = 0;
        set_req(1, 0, 0, 0, 0, 0);
        chk("rst_mid_hold", resp0_valid, 0);
        @(negedge ACLK);
        ARESETN = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("rst_mid_no_resp", {resp0_valid, resp1_valid, RREADY}, 0);
        end
        @(negedge ACLK);
        set_req(0, 1, 0, 32'h7200, 0, 0);
        set_req(1, 1, 0, 32'h7300, 0, 0);
        #1 chk("rst_mid_tie", {req0_ready, req1_ready}, 2'b10);
        @(negedge ACLK);
        do_reset();

        // stalled slave: ARREADY 5 cycles late, RVALID 3 cycles late
        @(negedge ACLK);
        set_req(0, 1, 0, 32'h6000, 0, 0);
        set_req(1, 1, 0, 32'h6100, 0, 0);
        #1 chk("stall_ready", {req0_ready, req1_ready}, 2'b10);
        for (int c = 1; c <= 11; c++) begin
            @(negedge ACLK);
            if (c == 1)  set_req(0, 0, 0, 0, 0, 0);
            if (c == 11) set_req(1, 0, 0, 0, 0, 0);
            ARREADY = (c == 6);
            RVALID = (c == 10); RDATA = 32'h600D_D00D; RRESP = 0;
            #1;
            if (c <= 10) begin
                chk("stall_arvalid", ARVALID, (c <= 6));
                if (c <= 6) chk("stall_araddr", ARADDR, 32'h6000);
                chk("stall_rready", RREADY, (c >= 7));
                chk("stall_no_resp", resp0_valid, 0);
                chk("stall_no_grant", req1_ready, 0);
            end else begin
                chk("stall_resp", resp0_valid, 1);
                chk("stall_rdata", resp0_rdata, 32'h600D_D00D);
            end
        end
        @(negedge ACLK);
        chk("stall_resp_end", resp0_valid, 0);

        // randomized traffic against the transaction-level model
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = $urandom;
            slave_mem[i] = ref_mem[i];
        end
        for (int i = 0; i < 2; i++) begin
            held[i] = 0; v[i] = 0; rw[i] = 0; ra[i] = 0; rd[i] = 0; rs[i] = 0;
            issued[i] = 0; done[i] = 0;
        end
        busy_m = 0; last_m = 1; own_m = 0; e_wen = 0; pend_resp = 0; pend_err = 0;
        r_pend = 0; rv = 0; bv = 0; aw_seen = 0; w_seen = 0; wr_applied = 0;
        hold_ar = 0; hold_aw = 0; hold_w = 0; pend_port = 0; cyc = 0;
        e_addr = 0; e_wdata = 0; e_wstrb = 0; e_rd = 0; sl_idx = 0;
        sl_awaddr = 0; sl_wdata = 0; sl_wstrb = 0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;

        while (cyc < LIMIT && (done[0] < NRAND || done[1] < NRAND || busy_m || pend_resp)) begin
            @(negedge ACLK);
            cyc++;
            for (int q = 0; q < 2; q++) begin
                chk("rnd_resp_valid", get_rv(q), pend_resp && pend_port == q);
                if (pend_resp && pend_port == q) begin
                    chk("rnd_resp_rdata", get_rdata(q), held[q]);
                    chk("rnd_resp_err", get_err(q), pend_err);
                end else begin
                    chk("rnd_err_idle", get_err(q), 0);
                end
            end
            pend_resp = 0;
            if (hold_ar) begin
                chk("rnd_ar_stable", ARVALID, 1);
                chk("rnd_araddr_stable", ARADDR, p_araddr);
            end
            if (hold_aw) begin
                chk("rnd_aw_stable", AWVALID, 1);
                chk("rnd_awaddr_stable", AWADDR, p_awaddr);
            end
            if (hold_w) begin
                chk("rnd_w_stable", WVALID, 1);
                chk("rnd_wdata_stable", {WDATA, 28'h0, WSTRB}, {p_wdata, 28'h0, p_wstrb});
            end

            ARREADY = ($urandom_range(0, 2) == 0);
            AWREADY = ($urandom_range(0, 2) == 0);
            WREADY  = ($urandom_range(0, 2) == 0);
            if (r_pend && !rv && $urandom_range(0, 2) == 0) begin
                rv = 1;
                RDATA = slave_mem[sl_idx];
                RRESP = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            if (!rv) RDATA = $urandom;
            RVALID = rv;
            if (aw_seen && w_seen && !bv && $urandom_range(0, 2) == 0) begin
                bv = 1;
                BRESP = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            BVALID = bv;
            for (int q = 0; q < 2; q++) begin
                if (!v[q] && issued[q] < NRAND && $urandom_range(0, 1) == 1) begin
                    v[q] = 1;
                    rw[q] = 1'($urandom_range(0, 1));
                    ra[q] = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
                    rd[q] = $urandom;
                    rs[q] = 4'($urandom_range(0, 15));
                    issued[q]++;
                end
                set_req(q, v[q], rw[q], ra[q], rd[q], rs[q]);
            end
            #1;

            for (int q = 0; q < 2; q++)
                chk("rnd_ready", get_ready(q), !busy_m && v[q] && (!v[1 - q] || last_m != q));
            for (int q = 0; q < 2; q++) begin
                if (v[q] && get_ready(q)) begin
                    busy_m = 1; own_m = q[0]; last_m = q[0];
                    e_wen = rw[q]; e_addr = ra[q]; e_wdata = rd[q]; e_wstrb = rs[q];
                    if (rw[q]) ref_mem[ra[q][4:2]] = merge(ref_mem[ra[q][4:2]], rd[q], rs[q]);
                    else e_rd = ref_mem[ra[q][4:2]];
                    v[q] = 0;
                end
            end
            if (RREADY) chk("rnd_rready_after_ar", r_pend, 1);
            if (BREADY) chk("rnd_bready_after_aw_w", aw_seen && w_seen, 1);
            if (ARVALID && ARREADY) begin
                chk("rnd_araddr", ARADDR, e_addr);
                chk("rnd_ar_is_read", e_wen, 0);
                r_pend = 1; sl_idx = ARADDR[4:2];
            end
            if (RVALID && RREADY) begin
                rv = 0; r_pend = 0;
                pend_resp = 1; pend_port = int'(own_m); pend_err = (RRESP != 2'b00);
                held[own_m] = e_rd;
                busy_m = 0; done[own_m]++;
            end
            if (AWVALID && AWREADY) begin
                chk("rnd_awaddr", AWADDR, e_addr);
                aw_seen = 1; sl_awaddr = AWADDR;
            end
            if (WVALID && WREADY) begin
                chk("rnd_wdata", WDATA, e_wdata);
                chk("rnd_wstrb", WSTRB, e_wstrb);
                w_seen = 1; sl_wdata = WDATA; sl_wstrb = WSTRB;
            end
            if (aw_seen && w_seen && !wr_applied) begin
                slave_mem[sl_awaddr[4:2]] = merge(slave_mem[sl_awaddr[4:2]], sl_wdata, sl_wstrb);
                wr_applied = 1;
            end
            if (BVALID && BREADY) begin
                bv = 0; aw_seen = 0; w_seen = 0; wr_applied = 0;
                pend_resp = 1; pend_port = int'(own_m); pend_err = (BRESP != 2'b00);
                busy_m = 0; done[own_m]++;
            end
            hold_ar = ARVALID && !ARREADY; p_araddr = ARADDR;
            hold_aw = AWVALID && !AWREADY; p_awaddr = AWADDR;
            hold_w  = WVALID && !WREADY;   p_wdata = WDATA; p_wstrb = WSTRB;
        end
        chk("rnd_completed", 32'(done[0] + done[1]), 32'(2 * NRAND));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-requester arbiter sharing one AXI-lite master port between the instruction-fetch unit (port 0) and the load/store unit (port 1). Arbitrates with round-robin priority, latches the winning request, and drives a single read or write transaction to completion. Returns a one-cycle response pulse to the granted requester. Sits between the CPU pipeline and the AXI-lite interconnect, in place of direct requester-to-master wiring.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; WSTRB width is DATA_W/8
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request from port N (N = 0, 1)
- reqN_wen  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  byte address
- reqN_wdata  in  DATA_W  write data
- reqN_wstrb  in  DATA_W/8  byte enables
- reqN_ready  out  1  request accepted this cycle
- respN_valid  out  1  one-cycle completion pulse
- respN_rdata  out  DATA_W  read data, held until the next response on that port
- respN_err  out  1  RRESP/BRESP was nonzero; valid with respN_valid
- ARADDR/ARVALID out, ARREADY in: AXI-lite read-address channel
- RDATA/RRESP[1:0]/RVALID in, RREADY out: read-data channel
- AWADDR/AWVALID out, AWREADY in: write-address channel
- AWPROT  out  3  constant 3'b000
- WDATA/WSTRB/WVALID out, WREADY in: write-data channel
- BRESP[1:0]/BVALID in, BREADY out: write-response channel

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- **IDLE:**
  - If one port is valid, grant it.
  - If both are valid, grant the port that was not granted last.
  - `last` resets to 1, so port 0 wins the first tie.
  - On grant: pulse reqN_ready, latch addr/wdata/wstrb/wen and the owner, update `last`.
  - Go to RD_ADDR (read) or WR_REQ (write).
- **RD_ADDR:** ARVALID=1 with the latched address. On ARVALID&ARREADY go to RD_DATA.
- **RD_DATA:** RREADY=1. On RVALID, register RDATA and (RRESP!=0) to the owner's rdata/err, pulse the owner's resp_valid, go to IDLE.
- **WR_REQ:**
  - AWVALID and WVALID both assert on entry.
  - Each deasserts independently after its own handshake and is never reasserted.
  - AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- **WR_RESP:** BREADY=1. On BVALID, pulse the owner's resp_valid with err=(BRESP!=0); rdata is unchanged. Go to IDLE.
- No requests are accepted outside IDLE.
- Requesters hold valid and payload until ready. The non-winning port stays pending.
- AXI rules:
  - VALID signals never drop before their handshake.
  - Address and data stay stable while VALID is high.
  - The block never waits on READY before asserting VALID.
- **Reset** (any time, including mid-transaction):
  - State goes to IDLE, `last`=1.
  - All VALID/READY/resp outputs are 0; rdata, err and addresses are 0.
  - The in-flight transaction is abandoned and no response is issued.

## Timing
- All outputs are registered except reqN_ready, which is combinational from state and reqN_valid.
- Read, zero-wait slave: accept at T; ARVALID at T+1; RREADY at T+2; resp_valid at T+3, in IDLE. The next accept can happen at T+3.
- Write, zero-wait slave: accept at T; AWVALID/WVALID at T+1; BREADY at T+2; resp_valid at T+3.
- Each slave wait cycle adds one cycle to the total.
- With both ports continuously requesting, grants alternate 0,1,0,1.
- resp_valid is exactly one cycle wide.

## Test plan
- **Single read, port 0:**
  - Stimulus: req0 read 0x8000_0000; slave returns 0xDEAD_BEEF, RRESP=0, zero wait.
  - Required: req0_ready at T; ARVALID at T+1; resp0_valid at T+3 with rdata=0xDEAD_BEEF, err=0.
- **Single write, port 1, with split handshakes:**
  - Stimulus: req1 write 0x1000 with data 0x1234_5678, wstrb=4'b0011; AWREADY arrives 2 cycles before WREADY.
  - Required: AWVALID drops after its handshake while WVALID stays high; B is accepted only after both handshakes; resp1_valid once.
- **Simultaneous requests after reset:**
  - Stimulus: both ports read.
  - Required: port 0 granted first, port 1 second; 4 back-to-back pairs alternate 0,1,0,1; nothing is lost.
- **Error response:**
  - Stimulus: RRESP=2'b10 on a port 1 read; BRESP=2'b11 on a port 0 write.
  - Required: the matching respN_err=1, and only on that response pulse.
- **Reset mid-read:**
  - Stimulus: ARESETN low during RD_DATA with RVALID pending.
  - Required: all outputs 0 immediately; no resp pulse; a port 1 request after release is granted before port 0 is not forced (port 0 wins a tie).
- **Slave stalls:**
  - Stimulus: ARREADY delayed 5 cycles, RVALID delayed 3 cycles.
  - Required: ARADDR stable throughout; no second grant; resp at T+3+8.
